// File: rtl/parking_slot_controller_pkg.sv
// Shared definitions for the parking slot controller: default sizing, FSM states
// and the one-hot to slot-index helper.
package parking_slot_controller_pkg;

  localparam int unsigned DEF_NUM_SLOTS = 3;
  localparam int unsigned DEF_TW        = 10;
  localparam int unsigned DEF_RATE      = 1;
  localparam int unsigned DEF_MIN_COST  = 1;
  localparam int unsigned ADDR_W        = 2;
  // A 2-bit memory address bounds the design to at most four slots.
  localparam int unsigned MAX_SLOTS     = 4;

  typedef enum logic [2:0] {
    IDLE,
    ENT,
    EXR,
    EXW,
    EXC
  } state_t;

  function automatic logic [ADDR_W-1:0] onehot_to_idx(input logic [MAX_SLOTS-1:0] oh);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
      if (oh[i]) idx = ADDR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/parking_slot_controller_slot_allocator.sv
// Lowest-free-slot priority encoder and all-occupied flag.
module slot_allocator
  import parking_slot_controller_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS
) (
  input  logic [NUM_SLOTS-1:0] slot_state,
  output logic [ADDR_W-1:0]    free_idx,
  output logic                 full
);

  // Scan downwards so the lowest free slot is the last one assigned.
  always_comb begin
    free_idx = '0;
    for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
      if (!slot_state[i-1]) free_idx = ADDR_W'(i - 1);
    end
  end

  assign full = &slot_state;

endmodule

// File: rtl/parking_slot_controller.sv
// Entry/exit transaction sequencer: switch edge detection, request arbitration,
// slot bookkeeping and the entry-time/cost memory handshake.
module parking_slot_controller
  import parking_slot_controller_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int unsigned TW        = DEF_TW,
  parameter int unsigned RATE      = DEF_RATE,
  parameter int unsigned MIN_COST  = DEF_MIN_COST
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 car_enter,
  input  logic                 car_exit,
  input  logic [NUM_SLOTS-1:0] car_sel,
  input  logic [TW-1:0]        timer_count,
  input  logic [TW-1:0]        mem_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  output logic                 mem_we_entry,
  output logic                 mem_we_cost,
  output logic [TW-1:0]        mem_wdata,
  output logic [NUM_SLOTS-1:0] slot_state,
  output logic [TW-1:0]        current_cost,
  output logic                 full,
  output logic                 busy,
  output logic                 err
);

  state_t state, state_n;

  logic                 enter_prev, exit_prev;
  logic                 enter_pend, exit_pend;
  logic                 enter_rise, exit_rise;
  logic                 enter_clr, exit_clr;
  logic [ADDR_W-1:0]    idx;
  logic                 idx_ld, slot_set, slot_clr;
  logic [ADDR_W-1:0]    free_idx;
  logic [MAX_SLOTS-1:0] sel_ext;
  logic [ADDR_W-1:0]    sel_idx;
  logic                 sel_ok;
  logic [TW-1:0]        diff, prod, cost;
  logic [TW-1:0]        rate_tw, min_cost_tw;

  slot_allocator #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_allocator (
    .slot_state (slot_state),
    .free_idx   (free_idx),
    .full       (full)
  );

  assign enter_rise = car_enter & ~enter_prev;
  assign exit_rise  = car_exit & ~exit_prev;

  always_comb begin
    sel_ext = '0;
    sel_ext[NUM_SLOTS-1:0] = car_sel;
  end

  assign sel_idx = onehot_to_idx(sel_ext);
  assign sel_ok  = $onehot(car_sel) && (|(car_sel & slot_state));

  // Modular subtraction absorbs timer wrap-around between entry and exit.
  assign rate_tw     = TW'(RATE);
  assign min_cost_tw = TW'(MIN_COST);
  assign diff        = timer_count - mem_rdata;
  assign prod        = diff * rate_tw;
  assign cost        = (diff == '0) ? min_cost_tw : prod;

  assign busy = (state != IDLE);

  always_comb begin
    state_n      = state;
    mem_addr     = '0;
    mem_rd       = 1'b0;
    mem_we_entry = 1'b0;
    mem_we_cost  = 1'b0;
    mem_wdata    = '0;
    err          = 1'b0;
    enter_clr    = 1'b0;
    exit_clr     = 1'b0;
    idx_ld       = 1'b0;
    slot_set     = 1'b0;
    slot_clr     = 1'b0;
    case (state)
      IDLE: begin
        if (exit_pend)       state_n = EXR;
        else if (enter_pend) state_n = ENT;
      end
      ENT: begin
        enter_clr = 1'b1;
        state_n   = IDLE;
        if (full) begin
          err = 1'b1;
        end else begin
          mem_addr     = free_idx;
          mem_wdata    = timer_count;
          mem_we_entry = 1'b1;
          slot_set     = 1'b1;
        end
      end
      EXR: begin
        exit_clr = 1'b1;
        if (sel_ok) begin
          mem_addr = sel_idx;
          mem_rd   = 1'b1;
          idx_ld   = 1'b1;
          state_n  = EXW;
        end else begin
          err     = 1'b1;
          state_n = IDLE;
        end
      end
      EXW: state_n = EXC;
      EXC: begin
        mem_addr    = idx;
        mem_wdata   = cost;
        mem_we_cost = 1'b1;
        slot_clr    = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      enter_prev   <= 1'b0;
      exit_prev    <= 1'b0;
      enter_pend   <= 1'b0;
      exit_pend    <= 1'b0;
      idx          <= '0;
      slot_state   <= '0;
      current_cost <= '0;
    end else begin
      state      <= state_n;
      enter_prev <= car_enter;
      exit_prev  <= car_exit;
      // A new edge outranks a same-cycle clear so the request is not lost.
      enter_pend <= enter_rise | (enter_pend & ~enter_clr);
      exit_pend  <= exit_rise | (exit_pend & ~exit_clr);
      if (idx_ld) idx <= sel_idx;
      if (slot_set) slot_state[free_idx] <= 1'b1;
      if (slot_clr) begin
        slot_state[idx] <= 1'b0;
        current_cost    <= cost;
      end
    end
  end

endmodule

// File: tb/tb_parking_slot_controller.sv
// Randomized bench for parking_slot_controller against a transaction-level
// occupancy/entry-time model with a behavioural entry-time memory.
module tb_parking_slot_controller;

  localparam int WIN = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       car_enter, car_exit;
  logic [2:0] car_sel;
  logic [9:0] timer_count;
  logic [9:0] mem_rdata;
  logic [1:0] mem_addr;
  logic       mem_rd, mem_we_entry, mem_we_cost;
  logic [9:0] mem_wdata;
  logic [2:0] slot_state;
  logic [9:0] current_cost;
  logic       full, busy, err;

  logic [9:0] mem [4];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit         occ [3];
  logic [9:0] etime [3];
  logic [9:0] last_cost = '0;

  // Expected per-cycle view: flags = {busy, err, rd, we_entry, we_cost}.
  logic [4:0] exp_flags [1:WIN];
  logic [1:0] exp_addr  [1:WIN];
  logic [9:0] exp_wdata [1:WIN];

  always #5 clk = ~clk;

  parking_slot_controller #(
    .NUM_SLOTS (3),
    .TW        (10),
    .RATE      (1),
    .MIN_COST  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .car_enter    (car_enter),
    .car_exit     (car_exit),
    .car_sel      (car_sel),
    .timer_count  (timer_count),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_we_entry (mem_we_entry),
    .mem_we_cost  (mem_we_cost),
    .mem_wdata    (mem_wdata),
    .slot_state   (slot_state),
    .current_cost (current_cost),
    .full         (full),
    .busy         (busy),
    .err          (err)
  );

  always @(posedge clk) begin
    if (mem_we_entry || mem_we_cost) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 1; i <= WIN; i++) begin
      exp_flags[i] = '0;
      exp_addr[i]  = '0;
      exp_wdata[i] = '0;
    end
  endtask

  task automatic model_entry(input int off, input logic [9:0] t);
    int f = -1;
    for (int i = 0; i < 3; i++) if (!occ[i] && f < 0) f = i;
    exp_flags[off][4] = 1'b1;
    if (f < 0) begin
      exp_flags[off][3] = 1'b1;
    end else begin
      exp_flags[off][1] = 1'b1;
      exp_addr[off]     = f[1:0];
      exp_wdata[off]    = t;
      occ[f]            = 1'b1;
      etime[f]          = t;
    end
  endtask

  task automatic model_exit(input int off, input logic [2:0] sel, input logic [9:0] t,
                            output int next_off);
    int         n = 0;
    int         s = 0;
    logic [9:0] d, c;
    for (int i = 0; i < 3; i++) if (sel[i]) begin n++; s = i; end
    if (n != 1 || !occ[s]) begin
      exp_flags[off] = 5'b11000;
      next_off = off + 2;
    end else begin
      exp_flags[off]     = 5'b10100;
      exp_addr[off]      = s[1:0];
      exp_flags[off + 1] = 5'b10000;
      d = t - etime[s];
      c = (d == 0) ? 10'd1 : 10'(d * 1);
      exp_flags[off + 2] = 5'b10001;
      exp_addr[off + 2]  = s[1:0];
      exp_wdata[off + 2] = c;
      last_cost = c;
      occ[s]    = 1'b0;
      next_off  = off + 4;
    end
  endtask

  task automatic check_slots(input string tag);
    logic [2:0] occ_v;
    occ_v = {occ[2], occ[1], occ[0]};
    check_eq({tag, " slot_state"}, slot_state, occ_v);
    check_eq({tag, " full"}, full, &occ_v);
    check_eq({tag, " current_cost"}, current_cost, last_cost);
  endtask

  task automatic run_txn(input string tag, input bit do_ent, input bit do_ex,
                         input logic [2:0] sel, input logic [9:0] t);
    int nxt = 2;
    clear_exp();
    if (do_ex) model_exit(2, sel, t, nxt);
    if (do_ent) model_entry(nxt, t);
    @(negedge clk);
    timer_count = t;
    car_sel     = sel;
    car_enter   = do_ent;
    car_exit    = do_ex;
    for (int i = 1; i <= WIN; i++) begin
      @(negedge clk);
      check_eq($sformatf("%s flags c%0d", tag, i),
               {busy, err, mem_rd, mem_we_entry, mem_we_cost}, exp_flags[i]);
      check_eq($sformatf("%s addr c%0d", tag, i), mem_addr, exp_addr[i]);
      check_eq($sformatf("%s wdata c%0d", tag, i), mem_wdata, exp_wdata[i]);
      if (i == 1) begin
        car_enter = 1'b0;
        car_exit  = 1'b0;
      end
      // Selector changes after the read cycle must not affect the exit.
      if (i == 3) car_sel = 3'($urandom_range(0, 7));
    end
    check_slots(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {mem_addr, mem_rd, mem_we_entry, mem_we_cost, mem_wdata, slot_state,
                   current_cost, full, busy, err}, 32'd0);
  endtask

  task automatic reset_in_exw();
    @(negedge clk);
    timer_count = 10'd100;
    car_sel     = 3'b001;
    car_exit    = 1'b1;
    @(negedge clk);
    car_exit = 1'b0;
    @(negedge clk);
    check_eq("rst_exw rd in EXR", mem_rd, 1'b1);
    @(negedge clk);
    check_eq("rst_exw busy in EXW", {busy, mem_rd, mem_we_cost}, 3'b100);
    reset = 1'b1;
    #1;
    check_all_zero("rst_exw outputs");
    for (int i = 0; i < 3; i++) occ[i] = 1'b0;
    last_cost = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("rst_exw quiet c%0d", i),
               {busy, err, mem_rd, mem_we_entry, mem_we_cost}, 5'b0);
    end
    check_slots("rst_exw");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] sel;
    logic [9:0] t;
    int         kind, s;

    reset       = 1'b1;
    car_enter   = 1'b0;
    car_exit    = 1'b0;
    car_sel     = '0;
    timer_count = '0;
    for (int i = 0; i < 3; i++) begin
      occ[i]   = 1'b0;
      etime[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset state");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after reset");

    run_txn("entry t5", 1, 0, 3'b000, 10'd5);
    run_txn("entry t10", 1, 0, 3'b000, 10'd10);
    run_txn("entry t12", 1, 0, 3'b000, 10'd12);
    run_txn("entry full", 1, 0, 3'b000, 10'd13);
    run_txn("exit s1 t17", 0, 1, 3'b010, 10'd17);
    run_txn("entry t1020", 1, 0, 3'b000, 10'd1020);
    run_txn("exit wrap", 0, 1, 3'b010, 10'd3);
    run_txn("entry t50", 1, 0, 3'b000, 10'd50);
    run_txn("exit same t", 0, 1, 3'b010, 10'd50);
    run_txn("exit not onehot", 0, 1, 3'b011, 10'd60);
    run_txn("exit free slot", 0, 1, 3'b010, 10'd61);
    run_txn("both s0", 1, 1, 3'b001, 10'd70);
    reset_in_exw();

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      t    = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) < 7) begin
        s   = $urandom_range(0, 2);
        sel = 3'b001 << s;
        if ($urandom_range(0, 3) == 0 && occ[s]) t = etime[s];
      end else begin
        sel = 3'($urandom_range(0, 7));
      end
      case (kind)
        0, 1:    run_txn($sformatf("rnd%0d ent", n), 1, 0, sel, t);
        2:       run_txn($sformatf("rnd%0d ex", n), 0, 1, sel, t);
        default: run_txn($sformatf("rnd%0d both", n), 1, 1, sel, t);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
